// File: rtl/matrix_scan_decoder_pkg.sv
// Shared types and default timing constants for the HYLL matrix scan decoder.
package matrix_scan_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    DRIVE = 2'd2
  } scan_state_e;

  typedef enum logic {
    MODE_AUTO   = 1'b0,
    MODE_MANUAL = 1'b1
  } scan_mode_e;

  localparam int unsigned DWELL_CYC_DEF = 1000;
  localparam int unsigned BLANK_CYC_DEF = 4;

endpackage

// File: rtl/matrix_scan_decoder_if.sv
// Control inputs and matrix-enable outputs of the scan decoder.
interface matrix_scan_decoder_if #(
  parameter int unsigned SEL_W = 2
) ();
  localparam int unsigned NCH = 1 << SEL_W;

  logic             scan_en_i;
  logic             mode_i;
  logic [SEL_W-1:0] manual_sel_i;
  logic [NCH-1:0]   ch_mask_i;
  logic [NCH-1:0]   sel_onehot_o;
  logic [SEL_W-1:0] sel_idx_o;
  logic             blank_o;
  logic             frame_start_o;

  modport slave (
    input  scan_en_i, mode_i, manual_sel_i, ch_mask_i,
    output sel_onehot_o, sel_idx_o, blank_o, frame_start_o
  );

  modport master (
    output scan_en_i, mode_i, manual_sel_i, ch_mask_i,
    input  sel_onehot_o, sel_idx_o, blank_o, frame_start_o
  );
endinterface

// File: rtl/matrix_scan_decoder_next_chan_pick.sv
// Rotate-priority finder: first unmasked channel strictly above cur_i, wrapping;
// returns cur_i itself only when it is the sole unmasked channel.
module next_chan_pick #(
  parameter int unsigned SEL_W = 2
) (
  input  logic [SEL_W-1:0]        cur_i,
  input  logic [(1<<SEL_W)-1:0]   mask_i,
  output logic [SEL_W-1:0]        next_o,
  output logic                    valid_o
);
  localparam int unsigned NCH = 1 << SEL_W;

  logic [SEL_W-1:0] cand;

  // Walk offsets from farthest to nearest so the nearest hit is written last.
  always_comb begin
    next_o  = '0;
    valid_o = 1'b0;
    cand    = '0;
    for (int unsigned k = NCH; k >= 1; k--) begin
      cand = cur_i + SEL_W'(k);
      if (mask_i[cand]) begin
        next_o  = cand;
        valid_o = 1'b1;
      end
    end
  end
endmodule

// File: rtl/matrix_scan_decoder.sv
// Time-multiplexed one-hot matrix select with blanking, auto scan and manual hold.
module matrix_scan_decoder
  import matrix_scan_pkg::*;
#(
  parameter int unsigned SEL_W     = 2,
  parameter int unsigned DWELL_CYC = DWELL_CYC_DEF,
  parameter int unsigned BLANK_CYC = BLANK_CYC_DEF
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  matrix_scan_decoder_if.slave bus
);
  localparam int unsigned NCH = 1 << SEL_W;
  localparam int unsigned DW  = $clog2(DWELL_CYC + 1);
  localparam int unsigned BW  = $clog2(BLANK_CYC + 1);

  scan_state_e      state_q, state_d;
  scan_mode_e       mode_q, mode_d, mode_in;
  logic [SEL_W-1:0] idx_q, idx_d;
  logic [SEL_W-1:0] last_q, last_d;
  logic [DW-1:0]    dwell_q, dwell_d;
  logic [BW-1:0]    blank_q, blank_d;
  logic             first_q, first_d;
  logic             frame_q, frame_d;

  logic [NCH-1:0]   onehot_q, onehot_d;
  logic [SEL_W-1:0] oidx_q, oidx_d;
  logic             oblank_q, oblank_d;
  logic             ofr_q, ofr_d;

  logic             en;
  logic [NCH-1:0]   mask;
  logic [SEL_W-1:0] msel;
  logic [SEL_W-1:0] nxt_idx, low_idx, tgt_idx;
  logic             nxt_vld, low_vld, tgt_ok;
  logic             go_idle, restart;

  assign en      = bus.scan_en_i;
  assign mask    = bus.ch_mask_i;
  assign msel    = bus.manual_sel_i;
  assign mode_in = scan_mode_e'(bus.mode_i);

  next_chan_pick #(.SEL_W(SEL_W)) u_pick_next (
    .cur_i   (idx_q),
    .mask_i  (mask),
    .next_o  (nxt_idx),
    .valid_o (nxt_vld)
  );

  next_chan_pick #(.SEL_W(SEL_W)) u_pick_low (
    .cur_i   ('1),
    .mask_i  (mask),
    .next_o  (low_idx),
    .valid_o (low_vld)
  );

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    idx_d   = idx_q;
    last_d  = last_q;
    dwell_d = dwell_q;
    blank_d = blank_q;
    first_d = first_q;
    frame_d = 1'b0;
    go_idle = 1'b0;
    restart = 1'b0;
    tgt_idx = idx_q;
    tgt_ok  = 1'b0;

    if (!en || mask == '0) begin
      go_idle = 1'b1;
    end else if (state_q == IDLE) begin
      mode_d  = mode_in;
      first_d = 1'b1;
      if (mode_in == MODE_MANUAL) begin
        tgt_idx = msel;
        tgt_ok  = mask[msel];
      end else begin
        tgt_idx = low_idx;
        tgt_ok  = low_vld;
      end
      restart = tgt_ok;
    end else if (mode_in != mode_q) begin
      mode_d  = mode_in;
      restart = 1'b1;
      if (mode_in == MODE_MANUAL) begin
        tgt_idx = msel;
        tgt_ok  = mask[msel];
      end else begin
        tgt_idx = nxt_idx;
        tgt_ok  = nxt_vld;
      end
    end else if (!mask[idx_q]) begin
      // Losing the held channel in manual mode has nowhere else to go.
      if (mode_q == MODE_MANUAL) begin
        go_idle = 1'b1;
      end else begin
        restart = 1'b1;
        tgt_idx = nxt_idx;
        tgt_ok  = nxt_vld;
      end
    end else if (mode_q == MODE_MANUAL && msel != idx_q) begin
      restart = 1'b1;
      tgt_idx = msel;
      tgt_ok  = mask[msel];
    end else if (state_q == BLANK) begin
      if (blank_q == BW'(BLANK_CYC - 1)) begin
        state_d = DRIVE;
        dwell_d = '0;
        last_d  = idx_q;
        first_d = 1'b0;
        frame_d = (mode_q == MODE_AUTO) && (first_q || idx_q <= last_q);
      end else begin
        blank_d = blank_q + BW'(1);
      end
    end else if (mode_q == MODE_AUTO) begin
      if (dwell_q == DW'(DWELL_CYC - 1)) begin
        restart = 1'b1;
        tgt_idx = nxt_idx;
        tgt_ok  = nxt_vld;
      end else begin
        dwell_d = dwell_q + DW'(1);
      end
    end

    if (go_idle || (restart && !tgt_ok)) begin
      state_d = IDLE;
      idx_d   = '0;
      blank_d = '0;
      dwell_d = '0;
    end else if (restart) begin
      state_d = BLANK;
      idx_d   = tgt_idx;
      blank_d = '0;
      dwell_d = '0;
    end
  end

  // Outputs follow the state one cycle later but drop at once when disabled.
  always_comb begin
    onehot_d = '0;
    if (en && state_q == DRIVE) onehot_d[idx_q] = 1'b1;
    oidx_d   = (en && state_q != IDLE) ? idx_q : '0;
    oblank_d = en && (state_q == BLANK);
    ofr_d    = en && frame_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      mode_q   <= MODE_AUTO;
      idx_q    <= '0;
      last_q   <= '0;
      dwell_q  <= '0;
      blank_q  <= '0;
      first_q  <= 1'b0;
      frame_q  <= 1'b0;
      onehot_q <= '0;
      oidx_q   <= '0;
      oblank_q <= 1'b0;
      ofr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      idx_q    <= idx_d;
      last_q   <= last_d;
      dwell_q  <= dwell_d;
      blank_q  <= blank_d;
      first_q  <= first_d;
      frame_q  <= frame_d;
      onehot_q <= onehot_d;
      oidx_q   <= oidx_d;
      oblank_q <= oblank_d;
      ofr_q    <= ofr_d;
    end
  end

  assign bus.sel_onehot_o  = onehot_q;
  assign bus.sel_idx_o     = oidx_q;
  assign bus.blank_o       = oblank_q;
  assign bus.frame_start_o = ofr_q;
endmodule

// File: tb/tb_matrix_scan_decoder.sv
// Randomised bench for matrix_scan_decoder against a slot-timeline reference model.
module tb_matrix_scan_decoder;
  localparam int unsigned SEL_W = 2;
  localparam int unsigned NCH   = 1 << SEL_W;
  localparam int          DWC   = 8;
  localparam int          BLC   = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  matrix_scan_decoder_if #(.SEL_W(SEL_W)) scan_if ();

  matrix_scan_decoder #(
    .SEL_W     (SEL_W),
    .DWELL_CYC (DWC),
    .BLANK_CYC (BLC)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (scan_if)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, got, want, $time);
    end
  endtask

  // Reference: an active slot is BLC blank cycles then DWC drive cycles, t counts from slot start.
  bit m_act;
  int m_ch, m_t, m_last;
  bit m_mode;
  int e_oh, e_idx;
  bit e_blank, e_fr;

  function automatic int next_above(int ch, logic [NCH-1:0] mk);
    for (int i = 1; i <= NCH; i++) begin
      if (mk[(ch + i) % NCH]) return (ch + i) % NCH;
    end
    return ch;
  endfunction

  function automatic int lowest(logic [NCH-1:0] mk);
    for (int i = 0; i < NCH; i++) if (mk[i]) return i;
    return 0;
  endfunction

  task automatic go_off();
    m_act = 0; m_ch = 0; m_t = 0; m_last = -1;
  endtask

  task automatic start(int c);
    m_act = 1; m_ch = c; m_t = 0;
  endtask

  task automatic model_edge();
    bit en, md;
    int ms, tgt;
    logic [NCH-1:0] mk;
    en = scan_if.scan_en_i; md = scan_if.mode_i;
    ms = int'(scan_if.manual_sel_i); mk = scan_if.ch_mask_i;
    e_blank = 0; e_oh = 0; e_idx = 0; e_fr = 0;
    if (!rst && en && m_act) begin
      e_idx = m_ch;
      if (m_t < BLC) e_blank = 1;
      else e_oh = 1 << m_ch;
      if (m_t == BLC && !m_mode && (m_last < 0 || m_ch <= m_last)) e_fr = 1;
    end
    if (m_act && m_t == BLC) m_last = m_ch;
    if (rst) begin
      go_off(); m_mode = 0;
    end else if (!en || mk == '0) begin
      go_off();
    end else if (!m_act) begin
      tgt = md ? ms : lowest(mk);
      if (mk[tgt]) begin m_mode = md; start(tgt); end
    end else if (md != m_mode) begin
      m_mode = md;
      if (md) begin
        if (mk[ms]) start(ms); else go_off();
      end else start(next_above(m_ch, mk));
    end else if (!mk[m_ch]) begin
      if (md) go_off(); else start(next_above(m_ch, mk));
    end else if (md && ms != m_ch) begin
      if (mk[ms]) start(ms); else go_off();
    end else if (!md && m_t == BLC + DWC - 1) begin
      start(next_above(m_ch, mk));
    end else if (!(md && m_t > BLC)) begin
      m_t++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check("onehot", 32'(scan_if.sel_onehot_o), e_oh);
    check("idx",    32'(scan_if.sel_idx_o),    e_idx);
    check("blank",  32'(scan_if.blank_o),      32'(e_blank));
    check("frame",  32'(scan_if.frame_start_o), 32'(e_fr));
    check("onehot_inv",
          32'($onehot0(scan_if.sel_onehot_o) && !(scan_if.blank_o && |scan_if.sel_onehot_o)), 1);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      assert ($onehot0(scan_if.sel_onehot_o) && !(scan_if.blank_o && |scan_if.sel_onehot_o))
        else $error("one-hot invariant broken");
    end
  end

  initial begin
    rst = 1'b1;
    scan_if.scan_en_i    = 1'b0;
    scan_if.mode_i       = 1'b0;
    scan_if.manual_sel_i = '0;
    scan_if.ch_mask_i    = 4'b1111;
    go_off(); m_mode = 0;
    repeat (3) tick();
    rst = 1'b0;

    scan_if.scan_en_i = 1'b1;
    repeat (100) tick();

    scan_if.ch_mask_i = 4'b1010;
    repeat (60) tick();

    scan_if.ch_mask_i    = 4'b1111;
    scan_if.mode_i       = 1'b1;
    scan_if.manual_sel_i = 2'd2;
    repeat (25) tick();
    scan_if.manual_sel_i = 2'd1;
    repeat (25) tick();

    scan_if.mode_i = 1'b0;
    repeat (30) tick();
    for (int i = 0; i < 50 && !(m_act && m_t > BLC + 1); i++) tick();
    scan_if.scan_en_i = 1'b0;
    repeat (3) tick();
    scan_if.scan_en_i = 1'b1;
    repeat (20) tick();

    for (int i = 0; i < 200 && !(m_act && m_ch == 2 && m_t == BLC + 3); i++) tick();
    scan_if.ch_mask_i = 4'b1011;
    repeat (30) tick();

    scan_if.ch_mask_i = 4'b1111;
    for (int i = 0; i < 200 && !(m_act && m_t == 1); i++) tick();
    rst = 1'b1; tick(); rst = 1'b0;
    repeat (10) tick();
    for (int i = 0; i < 200 && !(m_act && m_t == BLC + 3); i++) tick();
    rst = 1'b1; tick(); rst = 1'b0;
    repeat (10) tick();

    for (int n = 0; n < 3000; n++) begin
      rst = 1'b0;
      if ($urandom_range(0, 399) == 0) rst = 1'b1;
      if ($urandom_range(0, 149) == 0) scan_if.scan_en_i = ~scan_if.scan_en_i;
      if (!scan_if.scan_en_i && $urandom_range(0, 9) == 0) scan_if.scan_en_i = 1'b1;
      if ($urandom_range(0, 119) == 0) scan_if.mode_i = ~scan_if.mode_i;
      if ($urandom_range(0, 59) == 0) scan_if.manual_sel_i = SEL_W'($urandom_range(0, NCH - 1));
      if ($urandom_range(0, 79) == 0) begin
        if ($urandom_range(0, 3) == 0) scan_if.ch_mask_i = NCH'(1 << $urandom_range(0, NCH - 1));
        else scan_if.ch_mask_i = NCH'($urandom_range(0, (1 << NCH) - 1));
      end
      tick();
    end
    rst = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
